// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - parametrised shift-add sequential multiplier with start/busy/done handshake
// Optional two's-complement mode is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_mul_param #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sgn_q;

    logic               last_step;
    logic [WIDTH:0]     ext_high;
    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_next;

`ifndef SEQ_MUL_SIGNED_EN
    assign sgn_q = 1'b0;
`endif

    // One shift-add step; in signed mode the multiplier MSB carries negative weight,
    // so the last step subtracts and every shift is arithmetic.
    always_comb begin
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
        ext_high  = {sgn_q & acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
        ext_a     = {sgn_q & a_q[WIDTH-1], a_q};
        sum       = ext_high;
        if (acc_q[0]) begin
            if (sgn_q && last_step) begin
                sum = ext_high - ext_a;
            end else begin
                sum = ext_high + ext_a;
            end
        end
        acc_next = {sgn_q & sum[WIDTH], sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        product <= acc_next[2*WIDTH-1:0];
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        acc_q <= {{(WIDTH+1){1'b0}}, b};
                        cnt_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
                        sgn_q <= signed_mode;
`endif
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_param.sv
// tb/tb_seq_mul_param.sv - self-checking bench for seq_mul_param (WIDTH=4 and WIDTH=8 instances)
module tb_seq_mul_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        st4, st8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        sm4, sm8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  product4;
    logic [15:0] product8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_mul_param #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(st4), .a(a4), .b(b4),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_mode(sm4),
`endif
        .busy(busy4), .done(done4), .product(product4)
    );

    seq_mul_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .a(a8), .b(b8),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_mode(sm8),
`endif
        .busy(busy8), .done(done8), .product(product8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product of the operands, wrapped to 2*w bits
    function automatic logic [31:0] ref_mul(input int w, input int av, input int bv, input bit sm);
        longint x, y, mask;
        x = av;
        y = bv;
        if (sm) begin
            if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
            if (y >= (longint'(1) << (w - 1))) y -= (longint'(1) << w);
        end
        mask = (longint'(1) << (2 * w)) - 1;
        return 32'((x * y) & mask);
    endfunction

    task automatic start4(input logic [3:0] av, input logic [3:0] bv, input bit sm);
        @(negedge clk);
        st4 = 1'b1; a4 = av; b4 = bv; sm4 = sm;
        @(negedge clk);
        st4 = 1'b0; a4 = $urandom; b4 = $urandom;
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input bit sm);
        @(negedge clk);
        st8 = 1'b1; a8 = av; b8 = bv; sm8 = sm;
        @(negedge clk);
        st8 = 1'b0; a8 = $urandom; b8 = $urandom;
    endtask

    // Called just after the accepting edge; returns edges counted from it until done is seen
    task automatic wait4(output int edges, output int busy_n);
        edges = 1; busy_n = 0;
        while (!done4 && edges < 40) begin
            if (busy4) busy_n++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic wait8(output int edges, output int busy_n);
        edges = 1; busy_n = 0;
        while (!done8 && edges < 40) begin
            if (busy8) busy_n++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic mul4(input logic [3:0] av, input logic [3:0] bv, input bit sm,
                        input logic [7:0] exp, input string tag);
        int e, bn;
        start4(av, bv, sm);
        wait4(e, bn);
        check({tag, "_prod"}, product4, exp);
        check({tag, "_lat"}, e, 5);
        check({tag, "_busy"}, bn, 4);
    endtask

    initial begin
        int e, bn, pulses;
        logic [7:0] ra, rb;
        bit rs;
        reset = 1'b1; st4 = 1'b0; st8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0; sm4 = 1'b0; sm8 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_prod4", product4, 0);
        check("rst_busy8", busy8, 0);
        check("rst_prod8", product8, 0);
        reset = 1'b0;

        mul4(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15");
        mul4(4'd7,  4'd9,  1'b0, 8'h3F, "u7x9");
        mul4(4'd0,  4'd13, 1'b0, 8'h00, "u0x13");

        // start held during RUN must be ignored
        @(negedge clk);
        st4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        st4 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4) begin
                pulses++;
                check("ign_prod", product4, 8'h0F);
            end
            @(negedge clk);
        end
        check("ign_pulses", pulses, 1);
        check("ign_idle", busy4, 0);

        // back-to-back accept in the DONE cycle
        start4(4'd3, 4'd5, 1'b0);
        wait4(e, bn);
        check("b2b_first", product4, 8'h0F);
        st4 = 1'b1; a4 = 4'd12; b4 = 4'd11;
        @(negedge clk);
        st4 = 1'b0;
        check("b2b_nogap", busy4, 1);
        check("b2b_hold", product4, 8'h0F);
        wait4(e, bn);
        check("b2b_prod", product4, 8'h84);
        check("b2b_lat", e, 5);

        // reset in the second RUN cycle
        start4(4'd15, 4'd15, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy", busy4, 0);
        check("mid_done", done4, 0);
        check("mid_prod", product4, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) pulses++;
            @(negedge clk);
        end
        check("mid_nodone", pulses, 0);

`ifdef SEQ_MUL_SIGNED_EN
        mul4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
        mul4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3x5");
        mul4(4'h7, 4'hF, 1'b1, 8'hF9, "s_7xm1");
        mul4(4'hD, 4'h5, 1'b0, 8'h41, "s_off");
`endif

        start8(8'd255, 8'd255, 1'b0);
        wait8(e, bn);
        check("w8_max", product8, 16'hFE01);
        check("w8_max_lat", e, 9);
        start8(8'd128, 8'd2, 1'b0);
        wait8(e, bn);
        check("w8_128x2", product8, 16'h0100);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            start8(ra, rb, rs);
            wait8(e, bn);
            check("w8_rand", product8, ref_mul(8, int'(ra), int'(rb), rs));
            check("w8_rand_lat", e, 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
